dmem_copy_engine: RTL and testbench

- Initiator for the data-memory port. It drives the Addr/Wdata/MemRead/MemWrite/RData side of the single-cycle data memory on the CPU's behalf.
- It performs word-granular block copies (src to dst) and block fills (pattern to dst) without processor involvement.
- It sits beside the CPU datapath. It owns the data-memory port only while busy; external muxing grants it the port.

---
 rtl/dmem_copy_engine.sv | 129 ++++++++++++
 tb/tb_dmem_copy_engine.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_copy_engine.sv
// rtl/dmem_copy_engine.sv - word-granular block copy/fill initiator for the data-memory port
module dmem_copy_engine #(
    parameter int DEPTH = 256,
    parameter int LEN_W = 9
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [31:0]      src,
    input  logic [31:0]      dst,
    input  logic [LEN_W-1:0] len,
    input  logic [31:0]      pattern,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [LEN_W-1:0] count,
    output logic [31:0]      Addr,
    output logic [31:0]      Wdata,
    output logic             MemRead,
    output logic             MemWrite,
    input  logic [31:0]      RData
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [32:0] DEPTH_W = 33'(DEPTH);

    state_t           state;
    state_t           state_nxt;
    logic             mode_r;
    logic             desc_r;
    logic [LEN_W-1:0] len_r;
    logic [31:0]      pattern_r;
    logic [31:0]      src_ptr;
    logic [31:0]      dst_ptr;
    logic [31:0]      data_r;

    logic [32:0]      src_end;
    logic [32:0]      dst_end;
    logic             range_err;
    logic             overlap;
    logic             last_word;

    // 33-bit end addresses so a source/destination near 2^32 cannot wrap into range
    assign src_end   = {1'b0, src} + 33'(len);
    assign dst_end   = {1'b0, dst} + 33'(len);
    assign range_err = (dst_end > DEPTH_W) || (!mode && (src_end > DEPTH_W));
    assign overlap   = !mode && (dst > src) && ({1'b0, dst} < src_end);
    assign last_word = (count == len_r - LEN_W'(1));

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        Addr      = 32'd0;
        Wdata     = 32'd0;
        case (state)
            IDLE: begin
                if (start) begin
                    if ((len == '0) || range_err) state_nxt = DONE;
                    else if (mode)                 state_nxt = WRITE;
                    else                           state_nxt = READ;
                end
            end
            READ: begin
                busy      = 1'b1;
                MemRead   = 1'b1;
                Addr      = src_ptr;
                state_nxt = WRITE;
            end
            WRITE: begin
                busy     = 1'b1;
                MemWrite = 1'b1;
                Addr     = dst_ptr;
                Wdata    = mode_r ? pattern_r : data_r;
                if (last_word)    state_nxt = DONE;
                else if (!mode_r) state_nxt = READ;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            mode_r    <= 1'b0;
            desc_r    <= 1'b0;
            len_r     <= '0;
            pattern_r <= 32'd0;
            src_ptr   <= 32'd0;
            dst_ptr   <= 32'd0;
            data_r    <= 32'd0;
            count     <= '0;
            error     <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_r    <= mode;
                        desc_r    <= overlap;
                        len_r     <= len;
                        pattern_r <= pattern;
                        count     <= '0;
                        error     <= (len != '0) && range_err;
                        // Overlapping forward copy walks from the top so no source word is clobbered early
                        src_ptr   <= overlap ? src + 32'(len) - 32'd1 : src;
                        dst_ptr   <= overlap ? dst + 32'(len) - 32'd1 : dst;
                    end
                end
                READ: data_r <= RData;
                WRITE: begin
                    count   <= count + LEN_W'(1);
                    src_ptr <= desc_r ? src_ptr - 32'd1 : src_ptr + 32'd1;
                    dst_ptr <= desc_r ? dst_ptr - 32'd1 : dst_ptr + 32'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_copy_engine.sv
// tb/tb_dmem_copy_engine.sv - randomized self-checking bench for dmem_copy_engine
module tb_dmem_copy_engine;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        mode;
    logic [31:0] src;
    logic [31:0] dst;
    logic [8:0]  len;
    logic [31:0] pattern;
    logic        busy;
    logic        done;
    logic        error;
    logic [8:0]  count;
    logic [31:0] Addr;
    logic [31:0] Wdata;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] RData;

    logic [31:0] mem     [256];
    logic [31:0] exp_mem [256];
    logic        pl_en;
    logic [7:0]  pl_addr;
    logic [31:0] pl_data;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clock = ~clock;

    dmem_copy_engine #(.DEPTH(256), .LEN_W(9)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .mode     (mode),
        .src      (src),
        .dst      (dst),
        .len      (len),
        .pattern  (pattern),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .count    (count),
        .Addr     (Addr),
        .Wdata    (Wdata),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .RData    (RData)
    );

    always @(posedge clock) begin
        if (pl_en)         mem[pl_addr]   <= pl_data;
        else if (MemWrite) mem[Addr[7:0]] <= Wdata;
    end
    assign RData = MemRead ? mem[Addr[7:0]] : 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic preload(input int a, input logic [31:0] v);
        @(negedge clock);
        pl_en   = 1'b1;
        pl_addr = 8'(a);
        pl_data = v;
        @(negedge clock);
        pl_en   = 1'b0;
    endtask

    // memmove/memset reference: the whole result is computed from the pre-operation snapshot
    task automatic run_op(input string tag, input logic m, input logic [31:0] s, input logic [31:0] d,
                          input logic [8:0] l, input logic [31:0] p, input int stray, input bit poke_done);
        longint sl, dl, ll;
        bit err, desc, got_r, got_w;
        int exp_done, done_at, c, rd_n, wr_n, dn_n, bad, mism, exp_cnt, busy_after;
        logic [31:0] fra, fwa, cnt_at_done, err_at_done;
        sl = s; dl = d; ll = l;
        err  = (l != 0) && ((dl + ll > 256) || (!m && (sl + ll > 256)));
        desc = !m && (dl > sl) && (dl < sl + ll);
        for (int i = 0; i < 256; i++) exp_mem[i] = mem[i];
        if (!err) begin
            for (longint i = 0; i < ll; i++) begin
                if (m) exp_mem[int'(dl + i)] = p;
                else   exp_mem[int'(dl + i)] = mem[int'(sl + i)];
            end
        end
        exp_done = (l == 0 || err) ? 1 : (m ? int'(ll) + 1 : 2 * int'(ll) + 1);
        exp_cnt  = (l == 0 || err) ? 0 : int'(ll);

        @(negedge clock);
        mode = m; src = s; dst = d; len = l; pattern = p; start = 1'b1;
        @(negedge clock);
        start = 1'b0; src = $urandom; dst = $urandom; len = 9'($urandom);
        pattern = $urandom; mode = 1'($urandom);

        c = 1; done_at = 0; rd_n = 0; wr_n = 0; dn_n = 0; bad = 0; busy_after = 0;
        got_r = 0; got_w = 0; fra = 0; fwa = 0; cnt_at_done = 0; err_at_done = 0;
        while (c <= 700) begin
            if (MemRead && MemWrite) bad++;
            if ((MemRead || MemWrite) && (Addr > 255)) bad++;
            if (!busy && (MemRead || MemWrite || Addr != 0 || Wdata != 0)) bad++;
            if (MemRead)  begin rd_n++; if (!got_r) fra = Addr; got_r = 1; end
            if (MemWrite) begin wr_n++; if (!got_w) fwa = Addr; got_w = 1; end
            if (done) begin
                dn_n++;
                if (done_at == 0) begin
                    done_at = c; cnt_at_done = 32'(count); err_at_done = 32'(error);
                end
            end
            if (done_at != 0 && c == done_at + 1 && busy) busy_after = 1;
            if (stray != 0 && c == stray) begin
                start = 1'b1; mode = ~m; src = 32'd0; dst = 32'd128; len = 9'd3; pattern = 32'h5555;
            end else if (poke_done && done_at != 0 && c == done_at) begin
                start = 1'b1; mode = 1'b0; src = 32'd0; dst = 32'd100; len = 9'd1;
            end else begin
                start = 1'b0;
            end
            if (done_at != 0 && c > done_at + 1) break;
            @(negedge clock);
            c++;
        end
        start = 1'b0;

        check({tag, " done_cycle"}, done_at, exp_done);
        check({tag, " done_pulses"}, dn_n, 1);
        check({tag, " count"}, cnt_at_done, exp_cnt);
        check({tag, " count_hold"}, 32'(count), exp_cnt);
        check({tag, " error"}, err_at_done, 32'(err));
        check({tag, " reads"}, rd_n, (!m && !err) ? int'(ll) : 0);
        check({tag, " writes"}, wr_n, err ? 0 : int'(ll));
        check({tag, " port_protocol"}, bad, 0);
        check({tag, " idle_after_done"}, busy_after, 0);
        if (l != 0 && !err) begin
            if (!m) check({tag, " first_read"}, fra, desc ? s + 32'(l) - 1 : s);
            check({tag, " first_write"}, fwa, desc ? d + 32'(l) - 1 : d);
        end
        mism = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) mism++;
        check({tag, " mem_words_wrong"}, mism, 0);
    endtask

    initial begin
        int si, di, li;
        reset = 1'b1; start = 1'b0; mode = 1'b0; src = 0; dst = 0; len = 0; pattern = 0;
        pl_en = 1'b0; pl_addr = 0; pl_data = 0;
        repeat (2) @(negedge clock);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset error", error, 0);
        check("reset count", count, 0);
        check("reset Addr", Addr, 0);
        check("reset Wdata", Wdata, 0);
        check("reset rw", {MemRead, MemWrite}, 0);
        reset = 1'b0;

        for (int i = 0; i < 256; i++) preload(i, $urandom);

        for (int i = 0; i < 4; i++) preload(10 + i, 32'hA0 + i);
        run_op("copy_basic", 1'b0, 32'd10, 32'd20, 9'd4, 32'd0, 0, 1'b0);
        for (int i = 0; i < 5; i++) preload(i, i + 1);
        run_op("copy_overlap", 1'b0, 32'd0, 32'd2, 9'd5, 32'd0, 0, 1'b0);
        run_op("fill_top", 1'b1, 32'd0, 32'd250, 9'd6, 32'hDEADBEEF, 0, 1'b0);
        run_op("copy_range_err", 1'b0, 32'd252, 32'd0, 9'd5, 32'd0, 0, 1'b0);
        run_op("len_zero", 1'b0, 32'd5, 32'd7, 9'd0, 32'd0, 0, 1'b0);
        run_op("fill_exact_end", 1'b1, 32'hFFFF_FFFF, 32'd252, 9'd4, 32'h1234_5678, 0, 1'b0);
        run_op("copy_no_wrap", 1'b0, 32'hFFFF_FFFE, 32'd0, 9'd4, 32'd0, 0, 1'b0);
        run_op("fill_past_end", 1'b1, 32'd0, 32'd256, 9'd1, 32'd7, 0, 1'b0);
        run_op("copy_stray_start", 1'b0, 32'd40, 32'd60, 9'd6, 32'd0, 3, 1'b0);
        run_op("fill_start_in_done", 1'b1, 32'd0, 32'd100, 9'd3, 32'hCAFE, 0, 1'b1);

        @(negedge clock);
        mode = 1'b0; src = 32'd30; dst = 32'd40; len = 9'd8; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        check("rst_mid busy_before", busy, 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rst_mid busy", busy, 0);
        check("rst_mid done", done, 0);
        check("rst_mid count", count, 0);
        check("rst_mid error", error, 0);
        check("rst_mid Addr", Addr, 0);
        check("rst_mid Wdata", Wdata, 0);
        check("rst_mid rw", {MemRead, MemWrite}, 0);
        run_op("after_reset", 1'b0, 32'd30, 32'd40, 9'd8, 32'd0, 0, 1'b0);

        for (int k = 0; k < 30; k++) begin
            si = $urandom_range(0, 258);
            case ($urandom_range(0, 3))
                0:       di = si + $urandom_range(0, 5);
                1:       di = (si >= 5) ? si - $urandom_range(0, 5) : si;
                default: di = $urandom_range(0, 258);
            endcase
            case ($urandom_range(0, 7))
                0:       li = 0;
                1:       li = $urandom_range(200, 256);
                default: li = $urandom_range(1, 12);
            endcase
            run_op("random", 1'($urandom), 32'(si), 32'(di), 9'(li), $urandom, 0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
